serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around one structural one-bit full adder cell
//   (ports: sum, carryout, a, b, carryin) and a carry flop.

---
 rtl/full_adder.sv | 24 ++
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder.sv
// One-bit full adder cell, built from gates so it maps directly onto a library cell.
//   a, b     : operand bits
//   carryin  : carry into this bit
//   sum      : a ^ b ^ carryin
//   carryout : majority(a, b, carryin)
module full_adder (
  output wire sum,
  output wire carryout,
  input  wire a,
  input  wire b,
  input  wire carryin
);

  wire ab_x;
  wire ab_a;
  wire c_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, carryin);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, carryin);
  or  g_o0 (carryout, ab_a, c_a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on an accepted start pulse. One bit is added per clock.
// The result is published together with a one-cycle done pulse.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high; clears all state and outputs
//   start    : request an addition; sampled only in IDLE
//   a, b     : WIDTH-bit operands, captured on the accepting edge
//   carryin  : initial carry, captured on the accepting edge
//   busy     : high while in RUN or DONE
//   done     : one-cycle pulse, results just updated
//   sum      : registered result, held between operations
//   carryout : carry out of bit WIDTH-1
//   overflow : signed overflow (carry into MSB XOR carryout)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   a_sr_q,     a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,     b_sr_d;
  logic [WIDTH-1:0]   res_sr_q,   res_sr_d;
  logic               carry_q,    carry_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   sum_q,      sum_d;
  logic               carryout_q, carryout_d;
  logic               overflow_q, overflow_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  wire fa_sum;
  wire fa_co;

  // Single adder cell, fed from the operand shift-register LSBs and the carry flop.
  full_adder u_fa (
    .sum      (fa_sum),
    .carryout (fa_co),
    .a        (a_sr_q[0]),
    .b        (b_sr_q[0]),
    .carryin  (carry_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_sr_q   <= res_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_sr_d   = res_sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = carryin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: carry_q is still the carry into the MSB, so publish the
          // completed result directly instead of waiting a cycle.
          sum_d      = {fa_sum, res_sr_q[WIDTH-1:1]};
          carryout_d = fa_co;
          overflow_d = fa_co ^ carry_q;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, co8, ov8;
  logic [7:0] sum8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2, co2, ov2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .carryin  (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .carryout (co8),
    .overflow (ov8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .start    (start2),
    .a        (a2),
    .b        (b2),
    .carryin  (cin2),
    .busy     (busy2),
    .done     (done2),
    .sum      (sum2),
    .carryout (co2),
    .overflow (ov2)
  );

  // Stimulus only: start one 8-bit add and wait for done.
  // edges counts clock edges from the accepting edge (inclusive) to the edge after which done is seen.
  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      output int edges, output bit timed_out);
    @(negedge clk);
    a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 1;
    timed_out = 1'b0;
    while (!done8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!done8) timed_out = 1'b1;
  endtask

  task automatic run2(input logic [1:0] ai, input logic [1:0] bi, input logic ci,
                      output bit timed_out);
    int n;
    @(negedge clk);
    a2 = ai; b2 = bi; cin2 = ci; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    timed_out = 1'b0;
    while (!done2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done2) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, co8, ov8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b sum=%h co=%b ov=%b, required all 0", busy8, done8, sum8, co8, ov8);
    end
    checks++;
    if ({busy2, done2, sum2, co2, ov2} !== 6'h00) begin
      errors++;
      $display("FAIL reset_w2: busy=%b done=%b sum=%h co=%b ov=%b, required all 0", busy2, done2, sum2, co2, ov2);
    end
    // start already high when reset is released: accepted on the first edge
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_start: busy=%b, required 1", busy8);
    end
    n = 1;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || sum8 !== 8'h33) begin
      errors++;
      $display("FAIL reset_release_sum: done=%b sum=%h, required done=1 sum=33", done8, sum8);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[6];
    int   edges;
    bit   to;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].ci, edges, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: no done within 40 edges, required done", i);
      end
      if (i == 0) begin
        checks++;
        if (edges !== 9) begin
          errors++;
          $display("FAIL latency: done after %0d edges, required 9", edges);
        end
      end
      checks++;
      if (sum8 !== vecs[i].s || co8 !== vecs[i].co || ov8 !== vecs[i].ov || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d] %h+%h+%b: sum=%h co=%b ov=%b busy=%b, required sum=%h co=%b ov=%b busy=1",
                 i, vecs[i].a, vecs[i].b, vecs[i].ci, sum8, co8, ov8, busy8, vecs[i].s, vecs[i].co, vecs[i].ov);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== vecs[i].s) begin
        errors++;
        $display("FAIL done_pulse[%0d]: done=%b busy=%b sum=%h, required done=0 busy=0 sum=%h",
                 i, done8, busy8, sum8, vecs[i].s);
      end
    end
  endtask

  task automatic test_start_held();
    int ndone = 0;
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; start8 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        checks++;
        if (sum8 !== 8'h07 || co8 !== 1'b0 || ov8 !== 1'b0) begin
          errors++;
          $display("FAIL start_held_sum: sum=%h co=%b ov=%b, required 07 0 0", sum8, co8, ov8);
        end
      end
    end
    start8 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    checks++;
    if (ndone !== 2) begin
      errors++;
      $display("FAIL start_held_count: %0d done pulses, required 2", ndone);
    end
  endtask

  task automatic test_operand_change();
    int n;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    a8 = 8'h55;
    n = 2;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || sum8 !== 8'h46 || co8 !== 1'b0 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL operand_change: done=%b sum=%h co=%b ov=%b, required 1 46 0 0", done8, sum8, co8, ov8);
    end
  endtask

  task automatic test_reset_mid_run();
    int  edges;
    bit  to;
    int  ndone = 0;
    run8(8'h80, 8'h80, 1'b0, edges, to);
    checks++;
    if (to || sum8 !== 8'h00 || co8 !== 1'b1 || ov8 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: to=%b sum=%h co=%b ov=%b, required 0 00 1 1", to, sum8, co8, ov8);
    end
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, co8, ov8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h co=%b ov=%b, required all 0", busy8, done8, sum8, co8, ov8);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d cycles with done/busy, required 0", ndone);
    end
    run8(8'h21, 8'h43, 1'b1, edges, to);
    checks++;
    if (to || sum8 !== 8'h65 || co8 !== 1'b0 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: to=%b sum=%h co=%b ov=%b, required 0 65 0 0", to, sum8, co8, ov8);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, es;
    logic       rc, ec, eo;
    logic [8:0] full;
    int         edges;
    bit         to;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      full = 9'(ra) + 9'(rb) + 9'(rc);
      es = full[7:0];
      ec = full[8];
      eo = (ra[7] == rb[7]) && (es[7] != ra[7]);
      run8(ra, rb, rc, edges, to);
      checks++;
      if (to || edges !== 9 || sum8 !== es || co8 !== ec || ov8 !== eo) begin
        errors++;
        $display("FAIL random %h+%h+%b: to=%b edges=%0d sum=%h co=%b ov=%b, required edges=9 sum=%h co=%b ov=%b",
                 ra, rb, rc, to, edges, sum8, co8, ov8, es, ec, eo);
      end
    end
  endtask

  task automatic test_w2_exhaustive();
    logic [1:0] ta, tb, es;
    logic       tc, ec, eo;
    logic [2:0] full;
    bit         to;
    for (int i = 0; i < 32; i++) begin
      ta = 2'(i);
      tb = 2'(i >> 2);
      tc = 1'(i >> 4);
      full = 3'(ta) + 3'(tb) + 3'(tc);
      es = full[1:0];
      ec = full[2];
      eo = (ta[1] == tb[1]) && (es[1] != ta[1]);
      run2(ta, tb, tc, to);
      checks++;
      if (to || sum2 !== es || co2 !== ec || ov2 !== eo) begin
        errors++;
        $display("FAIL w2 %h+%h+%b: to=%b sum=%h co=%b ov=%b, required sum=%h co=%b ov=%b",
                 ta, tb, tc, to, sum2, co2, ov2, es, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_operand_change();
    test_reset_mid_run();
    test_random();
    test_w2_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
